// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the tohost test-status monitor
package rv32i_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TMO} tohost_state_t;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h8000_1000;
  localparam logic [30:0] TOHOST_TMO_CODE = 31'h7FFF_FFFF;
  localparam logic [31:0] TOHOST_PASS_VAL = 32'h1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: snoops dmem writes to the tohost/subtest mailboxes and
// reports subtest results, end-of-test status and watchdog expiry
module tohost_monitor
  import rv32i_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
  parameter logic [31:0] SUBTEST_ADDR   = TOHOST_ADDR + 32'd4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic [3:0]       dmem_wstrb,
  output logic             evt_valid,
  output logic             evt_pass,
  output logic [30:0]      evt_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             done,
  output logic             test_pass,
  output logic             timeout
);
  tohost_state_t state, state_n;
  logic [31:0] wdog;
  logic        wr, sub_hit, th_hit, fire, go, tp, ev_v, ev_p;
  logic [30:0] ev_c;
  always_comb begin
    go      = state == ST_IDLE && start;
    wr      = state == ST_RUN && dmem_we && dmem_wstrb == 4'hF;
    sub_hit = wr && dmem_addr == SUBTEST_ADDR;
    th_hit  = wr && dmem_addr == TOHOST_ADDR && dmem_wdata[0];
    // a mailbox accept in the expiry cycle pre-empts the watchdog
    fire    = state == ST_RUN && wdog >= TIMEOUT_CYCLES && !sub_hit && !th_hit;
    tp      = dmem_wdata == TOHOST_PASS_VAL && fail_cnt == '0;
    state_n = go ? ST_RUN : th_hit ? ST_DONE : fire ? ST_TMO : state;
    ev_v    = sub_hit || th_hit || fire;
    ev_p    = sub_hit ? dmem_wdata == 32'd0 : th_hit ? tp : 1'b0;
    ev_c    = sub_hit ? dmem_wdata[30:0] : th_hit ? dmem_wdata[31:1] : fire ? TOHOST_TMO_CODE : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_pass  <= 1'b0;
      evt_code  <= '0;
      done      <= 1'b0;
      test_pass <= 1'b0;
      timeout   <= 1'b0;
      wdog      <= '0;
    end else begin
      evt_valid <= ev_v;
      evt_pass  <= ev_p;
      evt_code  <= ev_c;
      done      <= done | th_hit | fire;
      test_pass <= test_pass | (th_hit && tp);
      timeout   <= timeout | fire;
      wdog      <= go ? '0 : state == ST_RUN ? wdog + 32'd1 : wdog;
    end
  end
  sat_counter #(.W(CNT_W)) u_pass (
    .clk(clk), .rst(rst), .clr(go), .inc(sub_hit && dmem_wdata == 32'd0), .cnt(pass_cnt)
  );
  sat_counter #(.W(CNT_W)) u_fail (
    .clk(clk), .rst(rst), .clr(go), .inc(sub_hit && dmem_wdata != 32'd0), .cnt(fail_cnt)
  );
endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: directed self-checking bench for tohost_monitor
module tb_tohost_monitor;
  localparam logic [31:0] TH = 32'h8000_1000;
  localparam logic [31:0] SB = 32'h8000_1004;
  logic clk = 0, rst = 0, start = 0, dmem_we = 0;
  logic [31:0] dmem_addr = 0, dmem_wdata = 0;
  logic [3:0] dmem_wstrb = 0;
  logic evt_valid, evt_pass, done, test_pass, timeout;
  logic [30:0] evt_code;
  logic [1:0] pass_cnt, fail_cnt;
  int checks = 0, failures = 0;

  tohost_monitor #(.TIMEOUT_CYCLES(10), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .evt_valid(evt_valid),
    .evt_pass(evt_pass), .evt_code(evt_code), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .done(done), .test_pass(test_pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
  endtask
  task automatic go();
    start = 1; @(posedge clk); #1; start = 0;
  endtask
  task automatic idle();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_we = 1; dmem_addr = a; dmem_wdata = d; dmem_wstrb = s;
    @(posedge clk); #1;
    dmem_we = 0; dmem_wstrb = 0;
  endtask

  task automatic test_reset();
    rst = 1; #1;
    checks++; if ({evt_valid, evt_pass, evt_code, pass_cnt, fail_cnt, done, test_pass, timeout} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {evt_valid, evt_pass, evt_code, pass_cnt, fail_cnt, done, test_pass, timeout});
    end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_subtests();
    do_reset(); go();
    wr(SB, 32'd0, 4'hF);
    checks++; if ({evt_valid, evt_pass} !== 2'b11 || evt_code !== 31'd0) begin failures++; $display("FAIL sub0a got v/p=%b code=%0d exp 11/0", {evt_valid, evt_pass}, evt_code); end
    wr(SB, 32'd0, 4'hF);
    checks++; if ({evt_valid, evt_pass} !== 2'b11 || pass_cnt !== 2'd2) begin failures++; $display("FAIL sub0b got v/p=%b cnt=%0d exp 11/2", {evt_valid, evt_pass}, pass_cnt); end
    wr(SB, 32'd5, 4'hF);
    checks++; if ({evt_valid, evt_pass} !== 2'b10 || evt_code !== 31'd5) begin failures++; $display("FAIL sub5 got v/p=%b code=%0d exp 10/5", {evt_valid, evt_pass}, evt_code); end
    checks++; if (pass_cnt !== 2'd2 || fail_cnt !== 2'd1) begin failures++; $display("FAIL counts got p=%0d f=%0d exp 2/1", pass_cnt, fail_cnt); end
    idle();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b exp=0", evt_valid); end
    wr(TH, 32'd1, 4'hF);
    checks++; if ({evt_valid, evt_pass, done, test_pass, timeout} !== 5'b10100 || evt_code !== 31'd0) begin
      failures++; $display("FAIL th1_after_fail got v/p/d/tp/to=%b code=%0d exp 10100/0", {evt_valid, evt_pass, done, test_pass, timeout}, evt_code);
    end
  endtask

  task automatic test_tohost_code();
    do_reset(); go();
    wr(TH, 32'd7, 4'hF);
    checks++; if ({evt_valid, evt_pass, done, test_pass} !== 4'b1010 || evt_code !== 31'd3) begin
      failures++; $display("FAIL th7 got v/p/d/tp=%b code=%0d exp 1010/3", {evt_valid, evt_pass, done, test_pass}, evt_code);
    end
    wr(SB, 32'd0, 4'hF);
    checks++; if (evt_valid !== 1'b0 || pass_cnt !== 2'd0 || done !== 1'b1) begin failures++; $display("FAIL done_absorbing got v=%b cnt=%0d d=%b exp 0/0/1", evt_valid, pass_cnt, done); end
    do_reset(); go();
    wr(TH, 32'd2, 4'hF);
    checks++; if (evt_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL syscall_ignored got v=%b d=%b exp 0/0", evt_valid, done); end
    wr(TH, 32'd1, 4'hF);
    checks++; if ({evt_valid, evt_pass, done, test_pass, timeout} !== 5'b11110) begin failures++; $display("FAIL th_pass got=%b exp=11110", {evt_valid, evt_pass, done, test_pass, timeout}); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    do_reset(); go();
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (done) begin n = i; break; end
    end
    checks++; if (n != 11) begin failures++; $display("FAIL tmo_edges got=%0d exp=11", n); end
    checks++; if ({evt_valid, evt_pass, timeout, test_pass} !== 4'b1010 || evt_code !== 31'h7FFF_FFFF) begin
      failures++; $display("FAIL tmo_event got v/p/to/tp=%b code=%h exp 1010/7fffffff", {evt_valid, evt_pass, timeout, test_pass}, evt_code);
    end
    go(); idle();
    checks++; if (evt_valid !== 1'b0 || done !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL tmo_absorbing got v=%b d=%b to=%b exp 0/1/1", evt_valid, done, timeout); end
  endtask

  task automatic test_mailbox_wins();
    do_reset(); go();
    for (int i = 1; i <= 10; i++) idle();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL early_done got=%b exp=0", done); end
    wr(TH, 32'd1, 4'hF);
    checks++; if ({done, test_pass, timeout, evt_pass} !== 4'b1101) begin failures++; $display("FAIL mailbox_wins got d/tp/to/p=%b exp 1101", {done, test_pass, timeout, evt_pass}); end
    idle(); idle();
    checks++; if (timeout !== 1'b0 || evt_valid !== 1'b0) begin failures++; $display("FAIL late_timeout got to=%b v=%b exp 0/0", timeout, evt_valid); end
  endtask

  task automatic test_ignored_and_saturate();
    logic [1:0] exp_cnt;
    do_reset();
    wr(SB, 32'd0, 4'hF);
    wr(TH, 32'd1, 4'hF);
    checks++; if (evt_valid !== 1'b0 || pass_cnt !== 2'd0 || done !== 1'b0) begin failures++; $display("FAIL idle_writes got v=%b cnt=%0d d=%b exp 0/0/0", evt_valid, pass_cnt, done); end
    go();
    wr(TH, 32'd1, 4'h3);
    checks++; if (evt_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL partial_strobe got v=%b d=%b exp 0/0", evt_valid, done); end
    for (int i = 1; i <= 5; i++) begin
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      wr(SB, 32'd0, 4'hF);
      checks++; if (evt_valid !== 1'b1 || pass_cnt !== exp_cnt) begin failures++; $display("FAIL sat_pass%0d got v=%b cnt=%0d exp 1/%0d", i, evt_valid, pass_cnt, exp_cnt); end
    end
    idle();
    checks++; if (pass_cnt !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", pass_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset(); go();
    wr(SB, 32'd0, 4'hF);
    wr(SB, 32'd0, 4'hF);
    #2 rst = 1; #1;
    checks++; if ({evt_valid, evt_pass, evt_code, pass_cnt, fail_cnt, done, test_pass, timeout} !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", {evt_valid, evt_pass, evt_code, pass_cnt, fail_cnt, done, test_pass, timeout});
    end
    @(posedge clk); #1; rst = 0;
    wr(SB, 32'd0, 4'hF);
    checks++; if (evt_valid !== 1'b0 || pass_cnt !== 2'd0) begin failures++; $display("FAIL back_to_idle got v=%b cnt=%0d exp 0/0", evt_valid, pass_cnt); end
  endtask

  initial begin
    test_reset();
    test_subtests();
    test_tohost_code();
    test_timeout();
    test_mailbox_wins();
    test_ignored_and_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
